// File: rtl/ex_seq_pkg.sv
// Shared definitions for the REP string-instruction sequencer:
// FSM state encoding, data-size codes and address-stride magnitudes.
package ex_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_e;

  localparam logic [1:0] DSZ_BYTE  = 2'd0;
  localparam logic [1:0] DSZ_WORD  = 2'd1;
  localparam logic [1:0] DSZ_DWORD = 2'd2;

  localparam logic [31:0] STRIDE_BYTE  = 32'd1;
  localparam logic [31:0] STRIDE_WORD  = 32'd2;
  localparam logic [31:0] STRIDE_DWORD = 32'd4;

  // Unsigned stride magnitude for a data-size code; unknown codes fall back to byte.
  function automatic logic [31:0] stride_mag(input logic [1:0] dsz);
    case (dsz)
      DSZ_WORD:  stride_mag = STRIDE_WORD;
      DSZ_DWORD: stride_mag = STRIDE_DWORD;
      default:   stride_mag = STRIDE_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/stride_gen_ex.sv
// Maps {data size, direction flag} to the signed 32-bit ESI/EDI delta.
// DF = 1 walks memory downwards, giving the two's-complement negative stride.
module stride_gen_ex
  import ex_seq_pkg::*;
(
  input  logic [1:0]  datasize,
  input  logic        df,
  output logic [31:0] stride
);

  logic [31:0] mag;

  // Select magnitude from size, then negate when walking downwards.
  always_comb begin
    mag    = stride_mag(datasize);
    stride = df ? (~mag + 32'd1) : mag;
  end

endmodule

// File: rtl/rep_sequencer_ex.sv
// REP/REPE/REPNE string-instruction sequencer for the execute stage.
// Holds the instruction in EX, issues one uop per iteration (MOVS/STOS) or a
// first/second uop pair (CMPS), decrements ECX and ends on exhaustion or ZF.
// Optional build macro REP_SEQ_PERF_CNT_EN adds a saturating iteration counter
// on output SEQ_iter_cnt.
module rep_sequencer_ex
  import ex_seq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EX_V,
  input  logic             EX_is_rep,
  input  logic             EX_is_cmps,
  input  logic             EX_de_repne,
  input  logic [CNT_W-1:0] EX_ECX,
  input  logic [1:0]       EX_de_datasize_all,
  input  logic             EX_DF,
  input  logic             ZF_in,
  input  logic             WB_stall,
  output logic             SEQ_busy,
  output logic             SEQ_uop_v,
  output logic             SEQ_cmps_first_uop,
  output logic             SEQ_cmps_second_uop,
  output logic [CNT_W-1:0] SEQ_ecx,
  output logic             SEQ_ld_ecx,
  output logic [31:0]      SEQ_stride,
  output logic             SEQ_done
`ifdef REP_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]      SEQ_iter_cnt
`endif
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             is_cmps_q, is_cmps_d;
  logic             repne_q, repne_d;
  logic [31:0]      stride_q, stride_d;
  logic             uop_v_q, uop_v_d;
  logic             first_q, first_d;
  logic             second_q, second_d;
  logic             ld_ecx_q, ld_ecx_d;
  logic             done_q, done_d;

  logic             start;
  logic             dec_en;
  logic [CNT_W-1:0] count_dec;
  logic             count_last;
  logic [31:0]      stride_w;

  stride_gen_ex u_stride (
    .datasize (EX_de_datasize_all),
    .df       (EX_DF),
    .stride   (stride_w)
  );

  // Next-state, counter and registered-output computation; WB_stall freezes everything.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    is_cmps_d  = is_cmps_q;
    repne_d    = repne_q;
    stride_d   = stride_q;
    dec_en     = 1'b0;
    count_dec  = count_q - CNT_W'(1);
    count_last = (count_dec == '0);
    start      = (state_q == ST_IDLE) & EX_V & EX_is_rep & ~WB_stall;

    if (!WB_stall) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            stride_d = stride_w;
            if (EX_ECX == '0) begin
              state_d = ST_DONE;
            end else begin
              count_d   = EX_ECX;
              is_cmps_d = EX_is_cmps;
              repne_d   = EX_de_repne;
              state_d   = ST_FIRST;
            end
          end
        end
        ST_FIRST: begin
          if (is_cmps_q) begin
            state_d = ST_SECOND;
          end else begin
            dec_en  = 1'b1;
            count_d = count_dec;
            state_d = count_last ? ST_DONE : ST_FIRST;
          end
        end
        ST_SECOND: begin
          dec_en  = 1'b1;
          count_d = count_dec;
          if (count_last | (repne_q & ZF_in) | (~repne_q & ~ZF_in))
            state_d = ST_DONE;
          else
            state_d = ST_FIRST;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are a pure decode of the state being entered, so they hold while frozen.
    uop_v_d  = (state_d == ST_FIRST) | (state_d == ST_SECOND);
    first_d  = (state_d == ST_FIRST) & is_cmps_d;
    second_d = (state_d == ST_SECOND);
    ld_ecx_d = ((state_d == ST_FIRST) & ~is_cmps_d) | (state_d == ST_SECOND);
    done_d   = (state_d == ST_DONE);
  end

  // FSM, iteration state and registered outputs; CLR aborts immediately.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      is_cmps_q <= 1'b0;
      repne_q   <= 1'b0;
      stride_q  <= STRIDE_BYTE;
      uop_v_q   <= 1'b0;
      first_q   <= 1'b0;
      second_q  <= 1'b0;
      ld_ecx_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      is_cmps_q <= is_cmps_d;
      repne_q   <= repne_d;
      stride_q  <= stride_d;
      uop_v_q   <= uop_v_d;
      first_q   <= first_d;
      second_q  <= second_d;
      ld_ecx_q  <= ld_ecx_d;
      done_q    <= done_d;
    end
  end

`ifdef REP_SEQ_PERF_CNT_EN
  logic [31:0] iter_cnt_q, iter_cnt_d;

  // Saturating count of decrements issued since reset.
  always_comb begin
    iter_cnt_d = iter_cnt_q;
    if (dec_en && (iter_cnt_q != 32'hFFFF_FFFF))
      iter_cnt_d = iter_cnt_q + 32'd1;
  end

  // Performance counter register.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) iter_cnt_q <= '0;
    else     iter_cnt_q <= iter_cnt_d;
  end

  assign SEQ_iter_cnt = iter_cnt_q;
`endif

  // Busy is combinational on start so the EX/DE latches hold in the accepting cycle.
  always_comb begin
    SEQ_busy = start | (state_q == ST_FIRST) | (state_q == ST_SECOND);
    SEQ_ecx  = ld_ecx_q ? (count_q - CNT_W'(1)) : count_q;
  end

  assign SEQ_uop_v           = uop_v_q;
  assign SEQ_cmps_first_uop  = first_q;
  assign SEQ_cmps_second_uop = second_q;
  assign SEQ_ld_ecx          = ld_ecx_q;
  assign SEQ_stride          = stride_q;
  assign SEQ_done            = done_q;

endmodule

// File: tb/tb_rep_sequencer_ex.sv
// Bench for rep_sequencer_ex: directed scenarios plus randomized transactions
// checked cycle by cycle against a per-iteration reference model.
module tb_rep_sequencer_ex;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        EX_V, EX_is_rep, EX_is_cmps, EX_de_repne, EX_DF, ZF_in, WB_stall;
  logic [31:0] EX_ECX;
  logic [1:0]  EX_de_datasize_all;
  logic        SEQ_busy, SEQ_uop_v, SEQ_cmps_first_uop, SEQ_cmps_second_uop;
  logic        SEQ_ld_ecx, SEQ_done;
  logic [31:0] SEQ_ecx, SEQ_stride;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          uop;
    bit          first;
    bit          second;
    bit          ld;
    bit          done;
    bit          busy;
    bit          zf;
    bit          chk_ecx;
    logic [31:0] ecx;
  } exp_t;

  rep_sequencer_ex dut (
    .CLK                 (CLK),
    .CLR                 (CLR),
    .EX_V                (EX_V),
    .EX_is_rep           (EX_is_rep),
    .EX_is_cmps          (EX_is_cmps),
    .EX_de_repne         (EX_de_repne),
    .EX_ECX              (EX_ECX),
    .EX_de_datasize_all  (EX_de_datasize_all),
    .EX_DF               (EX_DF),
    .ZF_in               (ZF_in),
    .WB_stall            (WB_stall),
    .SEQ_busy            (SEQ_busy),
    .SEQ_uop_v           (SEQ_uop_v),
    .SEQ_cmps_first_uop  (SEQ_cmps_first_uop),
    .SEQ_cmps_second_uop (SEQ_cmps_second_uop),
    .SEQ_ecx             (SEQ_ecx),
    .SEQ_ld_ecx          (SEQ_ld_ecx),
    .SEQ_stride          (SEQ_stride),
    .SEQ_done            (SEQ_done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ref_stride(input logic [1:0] sz, input bit df);
    int m;
    m = (sz == 2'd2) ? 4 : (sz == 2'd1) ? 2 : 1;
    return df ? 32'(-m) : 32'(m);
  endfunction

  function automatic exp_t mk(input bit uop, input bit first, input bit second, input bit ld,
                              input bit done, input bit busy, input bit zf, input bit chk,
                              input logic [31:0] ecx);
    exp_t e;
    e.uop = uop; e.first = first; e.second = second; e.ld = ld; e.done = done;
    e.busy = busy; e.zf = zf; e.chk_ecx = chk; e.ecx = ecx;
    return e;
  endfunction

  // One REP instruction: model the expected per-cycle outputs, then drive and compare.
  task automatic run_txn(input string tag, input logic [31:0] ecx, input bit cmps, input bit repne,
                         input logic [1:0] sz, input bit df, input logic [63:0] zf_bits,
                         input logic [63:0] stall_mask, input int stall_pct);
    exp_t        q[$];
    logic [31:0] r;
    logic [31:0] xs;
    int          it, idx, c;
    bit          term, z, st;
    xs = ref_stride(sz, df);
    if (ecx == 32'd0) begin
      q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 32'd0));
    end else begin
      r = ecx; it = 0; term = 0;
      while (!term && it < 1000) begin
        if (!cmps) begin
          q.push_back(mk(1, 0, 0, 1, 0, 1, 0, 1, r - 32'd1));
          term = (r == 32'd1);
        end else begin
          z = zf_bits[it % 64];
          q.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1, r));
          q.push_back(mk(1, 0, 1, 1, 0, 1, z, 1, r - 32'd1));
          term = (r == 32'd1) || (repne ? z : !z);
        end
        r = r - 32'd1;
        it++;
      end
      q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 32'd0));
    end

    c = 0;
    @(posedge CLK); #1;
    EX_V = 1'b1; EX_is_rep = 1'b1; EX_is_cmps = cmps; EX_de_repne = repne;
    EX_ECX = ecx; EX_de_datasize_all = sz; EX_DF = df; ZF_in = 1'($urandom);
    WB_stall = stall_mask[0];
    while (WB_stall) begin
      @(negedge CLK);
      total++;
      if ({SEQ_busy, SEQ_uop_v, SEQ_done} !== 3'b000)
        $display("FAIL %s start_blocked {busy,uop,done} got=%b want=000", tag, {SEQ_busy, SEQ_uop_v, SEQ_done});
      if ({SEQ_busy, SEQ_uop_v, SEQ_done} !== 3'b000) bad++;
      c++;
      @(posedge CLK); #1;
      WB_stall = (c < 64) && stall_mask[c];
    end
    @(negedge CLK);
    total++;
    if ({SEQ_busy, SEQ_uop_v, SEQ_done} !== 3'b100) begin
      bad++;
      $display("FAIL %s start_cycle {busy,uop,done} got=%b want=100", tag, {SEQ_busy, SEQ_uop_v, SEQ_done});
    end
    c++;
    idx = 0;
    while (idx < q.size()) begin
      @(posedge CLK); #1;
      st = ((c < 64) && stall_mask[c]) || ($urandom_range(99) < stall_pct);
      WB_stall = st;
      ZF_in = (q[idx].second && !st) ? q[idx].zf : 1'($urandom);
      @(negedge CLK);
      total++;
      if ({SEQ_uop_v, SEQ_cmps_first_uop, SEQ_cmps_second_uop, SEQ_ld_ecx, SEQ_done, SEQ_busy} !==
          {q[idx].uop, q[idx].first, q[idx].second, q[idx].ld, q[idx].done, q[idx].busy}) begin
        bad++;
        $display("FAIL %s cyc%0d {uop,first,second,ld,done,busy} got=%b want=%b", tag, c,
                 {SEQ_uop_v, SEQ_cmps_first_uop, SEQ_cmps_second_uop, SEQ_ld_ecx, SEQ_done, SEQ_busy},
                 {q[idx].uop, q[idx].first, q[idx].second, q[idx].ld, q[idx].done, q[idx].busy});
      end
      if (q[idx].chk_ecx) begin
        total++;
        if (SEQ_ecx !== q[idx].ecx) begin
          bad++;
          $display("FAIL %s cyc%0d ecx got=%h want=%h", tag, c, SEQ_ecx, q[idx].ecx);
        end
      end
      total++;
      if (SEQ_stride !== xs) begin
        bad++;
        $display("FAIL %s cyc%0d stride got=%h want=%h", tag, c, SEQ_stride, xs);
      end
      if (!st) idx++;
      c++;
    end
  endtask

  // Cycles with no REP instruction presented: nothing may issue.
  task automatic idle_cycles(input string tag, input int n, input bit nonrep);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK); #1;
      EX_V = nonrep; EX_is_rep = 1'b0; EX_ECX = $urandom; ZF_in = 1'($urandom);
      WB_stall = 1'($urandom);
      @(negedge CLK);
      total++;
      if ({SEQ_busy, SEQ_uop_v, SEQ_ld_ecx, SEQ_done} !== 4'b0000) begin
        bad++;
        $display("FAIL %s idle{busy,uop,ld,done} got=%b want=0000", tag, {SEQ_busy, SEQ_uop_v, SEQ_ld_ecx, SEQ_done});
      end
    end
    WB_stall = 1'b0;
  endtask

  task automatic test_reset();
    CLR = 1'b1; EX_V = 1'b0; EX_is_rep = 1'b0; EX_is_cmps = 1'b0; EX_de_repne = 1'b0;
    EX_ECX = 32'd0; EX_de_datasize_all = 2'd0; EX_DF = 1'b0; ZF_in = 1'b0; WB_stall = 1'b0;
    @(negedge CLK);
    total++;
    if ({SEQ_busy, SEQ_uop_v, SEQ_cmps_first_uop, SEQ_cmps_second_uop, SEQ_ld_ecx, SEQ_done} !== 6'b0) begin
      bad++;
      $display("FAIL reset flags got=%b want=000000", {SEQ_busy, SEQ_uop_v, SEQ_cmps_first_uop,
               SEQ_cmps_second_uop, SEQ_ld_ecx, SEQ_done});
    end
    total++;
    if ({SEQ_ecx, SEQ_stride} !== {32'd0, 32'd1}) begin
      bad++;
      $display("FAIL reset ecx/stride got=%h/%h want=0/1", SEQ_ecx, SEQ_stride);
    end
    @(posedge CLK); #1;
    CLR = 1'b0;
  endtask

  task automatic test_directed();
    run_txn("movs_d3", 32'd3, 0, 0, 2'd2, 0, 64'h0, 64'h0, 0);
    run_txn("repe_cmps_b5", 32'd5, 1, 0, 2'd0, 0, 64'h3, 64'h0, 0);
    run_txn("repne_cmps_w4", 32'd4, 1, 1, 2'd1, 1, 64'h0, 64'h0, 0);
    run_txn("stos_ecx0", 32'd0, 0, 0, 2'd2, 1, 64'h0, 64'h0, 0);
    idle_cycles("gap", 2, 0);
    run_txn("stall_second", 32'd3, 1, 0, 2'd1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1C, 0);
    run_txn("stall_at_start", 32'd2, 0, 0, 2'd0, 1, 64'h0, 64'h3, 0);
    run_txn("wrap_repne", 32'hFFFF_FFFF, 1, 1, 2'd2, 1, 64'h4, 64'h0, 0);
    idle_cycles("nonrep", 4, 1);
  endtask

  task automatic test_clr_abort();
    @(posedge CLK); #1;
    EX_V = 1'b1; EX_is_rep = 1'b1; EX_is_cmps = 1'b0; EX_de_repne = 1'b0;
    EX_ECX = 32'd10; EX_de_datasize_all = 2'd2; EX_DF = 1'b1; WB_stall = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      total++;
      if ({SEQ_uop_v, SEQ_ecx} !== {1'b1, 32'(10 - k)}) begin
        bad++;
        $display("FAIL clr_pre k%0d {uop,ecx} got=%b/%h want=1/%h", k, SEQ_uop_v, SEQ_ecx, 32'(10 - k));
      end
    end
    #1; CLR = 1'b1; EX_V = 1'b0;
    #1;
    total++;
    if ({SEQ_busy, SEQ_uop_v, SEQ_cmps_first_uop, SEQ_cmps_second_uop, SEQ_ld_ecx, SEQ_done} !== 6'b0) begin
      bad++;
      $display("FAIL clr_abort flags got=%b want=000000", {SEQ_busy, SEQ_uop_v, SEQ_cmps_first_uop,
               SEQ_cmps_second_uop, SEQ_ld_ecx, SEQ_done});
    end
    total++;
    if ({SEQ_ecx, SEQ_stride} !== {32'd0, 32'd1}) begin
      bad++;
      $display("FAIL clr_abort ecx/stride got=%h/%h want=0/1", SEQ_ecx, SEQ_stride);
    end
    @(posedge CLK); #1;
    CLR = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      total++;
      if ({SEQ_uop_v, SEQ_done, SEQ_busy} !== 3'b000) begin
        bad++;
        $display("FAIL clr_after k%0d {uop,done,busy} got=%b want=000", k, {SEQ_uop_v, SEQ_done, SEQ_busy});
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_random();
    logic [63:0] zb;
    for (int n = 0; n < 40; n++) begin
      zb = {$urandom, $urandom};
      run_txn("rand", 32'($urandom_range(6)), 1'($urandom), 1'($urandom), 2'($urandom_range(2)),
              1'($urandom), zb, 64'h0, 20);
      if ($urandom_range(2) == 0) idle_cycles("rand_gap", $urandom_range(1, 2), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_clr_abort();
    test_random();
    idle_cycles("tail", 2, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
